// File: rtl/sdr_pkg.sv
// rtl/sdr_pkg.sv - shared receiver-chain constants and CIC helper functions
package sdr_pkg;

  localparam int SDR_IN_W  = 8;
  localparam int SDR_OUT_W = 8;

  typedef logic [3:0] log2_t;

  function automatic int acc_width(input int in_w, input int stages, input int max_l2);
    return in_w + stages * max_l2;
  endfunction

  // R=1 is not a decimator, so a zero request is lifted to the smallest real ratio
  function automatic log2_t clamp_log2(input log2_t req, input int max_l2);
    if (req == 4'd0) return 4'd1;
    if (int'(req) > max_l2) return log2_t'(max_l2);
    return req;
  endfunction

endpackage

// File: rtl/cic_decim_iq_if.sv
// rtl/cic_decim_iq_if.sv - sample/ratio bundle between mixer, CIC and audio back-end
interface cic_decim_iq_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
);
  logic                    in_valid;
  logic signed [IN_W-1:0]  in_i;
  logic signed [IN_W-1:0]  in_q;
  logic [3:0]              dec_log2;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_i;
  logic signed [OUT_W-1:0] out_q;
  logic [3:0]              active_log2;

  modport master (
    output in_valid, in_i, in_q, dec_log2,
    input  out_valid, out_i, out_q, active_log2
  );

  modport slave (
    input  in_valid, in_i, in_q, dec_log2,
    output out_valid, out_i, out_q, active_log2
  );
endinterface

// File: rtl/cic_chain.sv
// rtl/cic_chain.sv - one channel of integrators, M=1 combs and gain normalisation
module cic_chain
  import sdr_pkg::*;
#(
  parameter int IN_W         = SDR_IN_W,
  parameter int OUT_W        = SDR_OUT_W,
  parameter int STAGES       = 3,
  parameter int MAX_DEC_LOG2 = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clr,
  input  logic                    i_smp,
  input  logic                    i_dec,
  input  logic                    i_load,
  input  log2_t                   i_log2,
  input  logic signed [IN_W-1:0]  i_x,
  output logic signed [OUT_W-1:0] o_y
);
  localparam int ACC_W = acc_width(IN_W, STAGES, MAX_DEC_LOG2);

  logic signed [ACC_W-1:0] r_integ [STAGES];
  logic signed [ACC_W-1:0] r_dly   [STAGES];
  logic signed [OUT_W-1:0] r_y;
  logic signed [ACC_W-1:0] w_integ_next [STAGES];
  logic signed [ACC_W-1:0] w_comb [STAGES+1];
  logic signed [ACC_W-1:0] w_x_ext;
  logic signed [OUT_W-1:0] w_y;
  int                      w_shift;

  assign w_x_ext = {{(ACC_W-IN_W){i_x[IN_W-1]}}, i_x};

  always_comb begin
    w_integ_next[0] = r_integ[0] + w_x_ext;
    for (int s = 1; s < STAGES; s++) w_integ_next[s] = r_integ[s] + r_integ[s-1];
  end

  // The deciding sample's own integrator update feeds the combs in the same cycle
  always_comb begin
    w_comb[0] = w_integ_next[STAGES-1];
    for (int s = 0; s < STAGES; s++) w_comb[s+1] = w_comb[s] - r_dly[s];
  end

  // Full-scale span is IN_W+STAGES*log2 bits; keep its top OUT_W bits (floor)
  assign w_shift = IN_W + STAGES * int'(i_log2) - OUT_W;
  assign w_y = OUT_W'((w_shift >= 0) ? (w_comb[STAGES] >>> w_shift)
                                     : (w_comb[STAGES] <<< -w_shift));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) begin
        r_integ[s] <= '0;
        r_dly[s]   <= '0;
      end
      r_y <= '0;
    end else if (i_clr) begin
      for (int s = 0; s < STAGES; s++) begin
        r_integ[s] <= '0;
        r_dly[s]   <= '0;
      end
    end else begin
      if (i_smp) for (int s = 0; s < STAGES; s++) r_integ[s] <= w_integ_next[s];
      if (i_dec) for (int s = 0; s < STAGES; s++) r_dly[s] <= w_comb[s];
      if (i_load) r_y <= w_y;
    end
  end

  assign o_y = r_y;
endmodule

// File: rtl/cic_decim_iq.sv
// rtl/cic_decim_iq.sv - lockstep I/Q CIC decimator with run-time 2^k ratio
module cic_decim_iq
  import sdr_pkg::*;
#(
  parameter int IN_W         = SDR_IN_W,
  parameter int OUT_W        = SDR_OUT_W,
  parameter int STAGES       = 3,
  parameter int MAX_DEC_LOG2 = 11
) (
  input logic           clk,
  input logic           reset,
  cic_decim_iq_if.slave bus
);
  localparam int CNT_W = MAX_DEC_LOG2;
  localparam int SET_W = $clog2(STAGES + 1);

  log2_t                   r_req;
  log2_t                   r_active;
  logic [CNT_W-1:0]        r_cnt;
  logic [SET_W-1:0]        r_settle;
  logic                    r_valid;
  logic                    w_change;
  logic                    w_smp;
  logic                    w_last;
  logic                    w_dec;
  logic                    w_settled;
  logic                    w_load;
  logic [CNT_W-1:0]        w_cnt_max;
  logic signed [OUT_W-1:0] w_out_i;
  logic signed [OUT_W-1:0] w_out_q;

  // A pending ratio change wins over any sample arriving in the same cycle
  assign w_change  = (r_req != r_active);
  assign w_smp     = bus.in_valid && !w_change;
  assign w_cnt_max = ~({CNT_W{1'b1}} << r_active);
  assign w_last    = (r_cnt == w_cnt_max);
  assign w_dec     = w_smp && w_last;
  assign w_settled = (r_settle == SET_W'(STAGES));
  assign w_load    = w_dec && w_settled;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req    <= 4'd1;
      r_active <= 4'd1;
      r_cnt    <= '0;
      r_settle <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_req   <= clamp_log2(bus.dec_log2, MAX_DEC_LOG2);
      r_valid <= w_load;
      if (w_change) begin
        r_active <= r_req;
        r_cnt    <= '0;
        r_settle <= '0;
      end else if (w_smp) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last && !w_settled) r_settle <= r_settle + 1'b1;
      end
    end
  end

  cic_chain #(.IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .MAX_DEC_LOG2(MAX_DEC_LOG2)) u_chain_i (
    .clk(clk), .reset(reset), .i_clr(w_change), .i_smp(w_smp), .i_dec(w_dec),
    .i_load(w_load), .i_log2(r_active), .i_x(bus.in_i), .o_y(w_out_i)
  );

  cic_chain #(.IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .MAX_DEC_LOG2(MAX_DEC_LOG2)) u_chain_q (
    .clk(clk), .reset(reset), .i_clr(w_change), .i_smp(w_smp), .i_dec(w_dec),
    .i_load(w_load), .i_log2(r_active), .i_x(bus.in_q), .o_y(w_out_q)
  );

  assign bus.out_valid   = r_valid;
  assign bus.out_i       = w_out_i;
  assign bus.out_q       = w_out_q;
  assign bus.active_log2 = r_active;
endmodule

// File: tb/tb_cic_decim_iq.sv
// tb/tb_cic_decim_iq.sv - directed self-checking bench for cic_decim_iq
module tb_cic_decim_iq;
  logic clk;
  logic reset;

  cic_decim_iq_if bus ();

  cic_decim_iq dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_strb, first_smp, first_cyc, min_gap, max_gap, bad_val;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] d);
    bus.in_valid = 1'b0;
    bus.dec_log2 = d;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
  endtask

  task automatic set_ratio(input logic [3:0] d);
    bus.in_valid = 1'b0;
    bus.dec_log2 = d;
    repeat (3) tick();
  endtask

  // Feed nsmp DC samples, one every 'period' clocks, and tally the strobes seen
  task automatic run(input int nsmp, input int period, input int xi, input int xq);
    int cyc;
    int k;
    int prev;
    cyc = 0; k = 0; prev = -1;
    n_strb = 0; first_smp = -1; first_cyc = -1; min_gap = 1 << 30; max_gap = 0; bad_val = 0;
    while (k < nsmp) begin
      for (int p = 0; p < period; p++) begin
        bus.in_valid = (p == 0);
        bus.in_i = 8'(xi);
        bus.in_q = 8'(xq);
        tick();
        cyc++;
        if (p == 0) k++;
        if (bus.out_valid === 1'b1) begin
          n_strb++;
          if (first_smp < 0) begin
            first_smp = k;
            first_cyc = cyc;
          end
          if (prev >= 0) begin
            if (cyc - prev < min_gap) min_gap = cyc - prev;
            if (cyc - prev > max_gap) max_gap = cyc - prev;
          end
          prev = cyc;
          if (int'(bus.out_i) != xi || int'(bus.out_q) != xq) bad_val++;
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_i = '0;
    bus.in_q = '0;
    bus.dec_log2 = 4'd3;
    reset = 1'b1;
    tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_i", bus.out_i, 0);
    check("rst_out_q", bus.out_q, 0);
    check("rst_active", bus.active_log2, 1);

    // R=8, DC every cycle
    do_reset(4'd3);
    check("s1_active", bus.active_log2, 3);
    run(64, 1, 16, -16);
    check("s1_strobes", n_strb, 5);
    check("s1_first_smp", first_smp, 32);
    check("s1_first_cyc", first_cyc, 32);
    check("s1_min_gap", min_gap, 8);
    check("s1_max_gap", max_gap, 8);
    check("s1_bad_val", bad_val, 0);
    tick();
    check("s1_valid_drop", bus.out_valid, 0);
    check("s1_hold_i", bus.out_i, 16);
    check("s1_hold_q", bus.out_q, -16);

    // R=8, one sample every 3 clocks
    do_reset(4'd3);
    run(48, 3, 16, 16);
    check("s3_strobes", n_strb, 3);
    check("s3_first_smp", first_smp, 32);
    check("s3_first_cyc", first_cyc, 94);
    check("s3_gap", max_gap, 24);
    check("s3_min_gap", min_gap, 24);
    check("s3_bad_val", bad_val, 0);

    // ratio change 3->5 mid-window with in_valid held high
    do_reset(4'd3);
    run(36, 1, 16, 16);
    check("s4_pre_strobes", n_strb, 1);
    bus.dec_log2 = 4'd5;
    run(1, 1, 16, 16);
    check("s4_active_old", bus.active_log2, 3);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("s4_active_new", bus.active_log2, 5);
    check("s4_no_valid", bus.out_valid, 0);
    run(160, 1, 16, 16);
    check("s4_strobes", n_strb, 2);
    check("s4_first_smp", first_smp, 128);
    check("s4_gap", max_gap, 32);
    check("s4_bad_val", bad_val, 0);

    // clamping: 0 -> 1 (R=2), 15 -> 11
    do_reset(4'd0);
    check("s5_active_lo", bus.active_log2, 1);
    run(16, 1, 16, 16);
    check("s5_strobes", n_strb, 5);
    check("s5_first_smp", first_smp, 8);
    check("s5_gap", max_gap, 2);
    check("s5_bad_val", bad_val, 0);
    set_ratio(4'd15);
    check("s5_active_hi", bus.active_log2, 11);

    // R=2048 full-scale DC, integrators wrap
    set_ratio(4'd11);
    run(10240, 1, -128, 127);
    check("s2_strobes", n_strb, 2);
    check("s2_first_smp", first_smp, 8192);
    check("s2_gap", max_gap, 2048);
    check("s2_bad_val", bad_val, 0);
    check("s2_out_i", bus.out_i, -128);
    check("s2_out_q", bus.out_q, 127);

    // asynchronous reset while the deciding sample is in flight
    do_reset(4'd3);
    run(71, 1, 16, -16);
    check("s6_pre_strobes", n_strb, 5);
    check("s6_pre_out_i", bus.out_i, 16);
    bus.in_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("s6_async_i", bus.out_i, 0);
    check("s6_async_q", bus.out_q, 0);
    check("s6_async_active", bus.active_log2, 1);
    tick();
    check("s6_no_pulse", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b0;
    set_ratio(4'd3);
    run(40, 1, 16, -16);
    check("s6_strobes", n_strb, 2);
    check("s6_first_smp", first_smp, 32);
    check("s6_bad_val", bad_val, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
